// File: rtl/spi_master_sched_pkg.sv
// Shared SPI types and constants: scheduler state encoding, default timing, width helpers.
package spi_master_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT_ACT,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } sched_state_t;

  localparam int SPI_WORD_LEN    = 8;
  localparam int SS_SETUP_DEF    = 4;
  localparam int SS_HOLD_DEF     = 4;
  localparam int ACT_TIMEOUT_DEF = 16;

  // ceil(log2(n)) but never below 1, so single-entry selectors still get a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_sched_rr_arbiter.sv
// Combinational round-robin pick: lowest set request at or after i_ptr, wrapping.
module rr_arbiter
  import spi_master_sched_pkg::*;
#(
  parameter int p_N = 2,
  localparam int PW = clog2_min1(p_N)
)(
  input  logic [p_N-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [p_N-1:0] o_sel,
  output logic           o_any
);

  logic [2*p_N-1:0] req2, sel2;
  logic [p_N-1:0]   rot, pick;

  // rotate so the pointer sits at bit 0, isolate lowest set bit, rotate back
  assign req2  = {i_req, i_req} >> i_ptr;
  assign rot   = req2[p_N-1:0];
  assign pick  = rot & (~rot + p_N'(1));
  assign sel2  = {{p_N{1'b0}}, pick} << i_ptr;
  assign o_sel = sel2[p_N-1:0] | sel2[2*p_N-1:p_N];
  assign o_any = |i_req;

endmodule

// File: rtl/spi_master_sched.sv
// Round-robin scheduler in front of spi_master: owns slave selects and the master's data/dv strobe.
module spi_master_sched
  import spi_master_sched_pkg::*;
#(
  parameter int p_WORD_LEN    = SPI_WORD_LEN,
  parameter int p_NUM_REQ     = 2,
  parameter int p_NUM_SLAVES  = 2,
  parameter int p_SS_SETUP    = SS_SETUP_DEF,
  parameter int p_SS_HOLD     = SS_HOLD_DEF,
  parameter int p_ACT_TIMEOUT = ACT_TIMEOUT_DEF,
  localparam int SSW = clog2_min1(p_NUM_SLAVES)
)(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [p_NUM_REQ-1:0]            i_req,
  input  logic [p_NUM_REQ*SSW-1:0]        i_req_ss,
  input  logic [p_NUM_REQ*p_WORD_LEN-1:0] i_req_data,
  output logic [p_NUM_REQ-1:0]            o_gnt,
  output logic [p_NUM_REQ-1:0]            o_done,
  output logic                            o_err,
  output logic [p_WORD_LEN-1:0]           o_rdata,
  output logic                            o_busy,
  output logic [p_NUM_SLAVES-1:0]         o_ss,
  output logic [p_WORD_LEN-1:0]           o_m_data,
  output logic                            o_m_dv,
  input  logic                            i_m_active,
  input  logic [p_WORD_LEN-1:0]           i_m_data
);

  localparam int PW = clog2_min1(p_NUM_REQ);
  localparam int CW = clog2_min1(max3(p_SS_SETUP, p_SS_HOLD, p_ACT_TIMEOUT) + 1);

  sched_state_t            state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [PW-1:0]           rr_ptr, ptr_nxt, arb_k;
  logic [p_NUM_REQ-1:0]    arb_sel, sel_q, sel_nxt, gnt_nxt, done_nxt;
  logic                    arb_any, bad_idx;
  logic                    err_q, err_nxt, err_o_nxt, dv_nxt, busy_nxt;
  logic [SSW-1:0]          arb_ss;
  logic [p_WORD_LEN-1:0]   arb_data, rx_q, rx_nxt, mdata_nxt, rdata_nxt;
  logic [p_NUM_SLAVES-1:0] ss_dec, ss_nxt;

  rr_arbiter #(.p_N(p_NUM_REQ)) u_arb (
    .i_req (i_req),
    .i_ptr (rr_ptr),
    .o_sel (arb_sel),
    .o_any (arb_any)
  );

  // pull the winner's slice out of the flat request buses and decode its select
  always_comb begin
    arb_k    = '0;
    arb_ss   = '0;
    arb_data = '0;
    for (int k = 0; k < p_NUM_REQ; k++) begin
      if (arb_sel[k]) begin
        arb_k    = PW'(k);
        arb_ss   = i_req_ss[k*SSW +: SSW];
        arb_data = i_req_data[k*p_WORD_LEN +: p_WORD_LEN];
      end
    end
    for (int s = 0; s < p_NUM_SLAVES; s++) begin
      ss_dec[s] = (int'(arb_ss) != s);
    end
  end

  assign bad_idx = (int'(arb_ss) >= p_NUM_SLAVES);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = rr_ptr;
    sel_nxt   = sel_q;
    err_nxt   = err_q;
    rx_nxt    = rx_q;
    ss_nxt    = o_ss;
    mdata_nxt = o_m_data;
    rdata_nxt = o_rdata;
    gnt_nxt   = '0;
    done_nxt  = '0;
    err_o_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          sel_nxt   = arb_sel;
          gnt_nxt   = arb_sel;
          mdata_nxt = arb_data;
          ptr_nxt   = (arb_k == PW'(p_NUM_REQ - 1)) ? '0 : arb_k + PW'(1);
          if (bad_idx) begin
            err_nxt   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            err_nxt   = 1'b0;
            ss_nxt    = ss_dec;
            cnt_nxt   = CW'(p_SS_SETUP - 1);
            state_nxt = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (cnt == '0) state_nxt = ST_START;
        else           cnt_nxt   = cnt - CW'(1);
      end
      ST_START: begin
        cnt_nxt   = CW'(p_ACT_TIMEOUT - 1);
        state_nxt = ST_WAIT_ACT;
      end
      ST_WAIT_ACT: begin
        if (i_m_active) begin
          state_nxt = ST_XFER;
        end else if (cnt == '0) begin
          err_nxt   = 1'b1;
          cnt_nxt   = CW'(p_SS_HOLD - 1);
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_XFER: begin
        // master drops active once the word is complete; its rx word is stable then
        if (!i_m_active) begin
          rx_nxt    = i_m_data;
          cnt_nxt   = CW'(p_SS_HOLD - 1);
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          ss_nxt    = '1;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_DONE) begin
      done_nxt  = sel_nxt;
      err_o_nxt = err_nxt;
      if (!err_nxt) rdata_nxt = rx_nxt;
    end
    dv_nxt   = (state_nxt == ST_START);
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      sel_q    <= '0;
      err_q    <= 1'b0;
      rx_q     <= '0;
      o_ss     <= '1;
      o_m_data <= '0;
      o_m_dv   <= 1'b0;
      o_gnt    <= '0;
      o_done   <= '0;
      o_err    <= 1'b0;
      o_rdata  <= '0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rr_ptr   <= ptr_nxt;
      sel_q    <= sel_nxt;
      err_q    <= err_nxt;
      rx_q     <= rx_nxt;
      o_ss     <= ss_nxt;
      o_m_data <= mdata_nxt;
      o_m_dv   <= dv_nxt;
      o_gnt    <= gnt_nxt;
      o_done   <= done_nxt;
      o_err    <= err_o_nxt;
      o_rdata  <= rdata_nxt;
      o_busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched; a small behavioural master answers each dv strobe.
module tb_spi_master_sched;

  localparam int WL = 8, NR = 2, NS = 3, SSW = 2;
  localparam int SETUP = 4, HOLD = 4, TMO = 16;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*SSW-1:0] req_ss = '0;
  logic [NR*WL-1:0]  req_data = '0;
  logic [NR-1:0]     o_gnt, o_done;
  logic              o_err, o_busy, o_m_dv;
  logic [WL-1:0]     o_rdata, o_m_data;
  logic [NS-1:0]     o_ss;
  logic              m_active = 1'b0;
  logic [WL-1:0]     m_data = '0;

  int checks = 0, errors = 0;
  int cyc = 0, dv_cnt = 0, bad_ss = 0, bad_dv = 0, rx_sel = 0;
  logic              master_en = 1'b1;
  logic [WL-1:0]     slave_word [NS];
  logic [WL-1:0]     tx_seen = '0;

  // three slaves so a 2-bit index of 3 is out of range
  spi_master_sched #(
    .p_WORD_LEN(WL), .p_NUM_REQ(NR), .p_NUM_SLAVES(NS),
    .p_SS_SETUP(SETUP), .p_SS_HOLD(HOLD), .p_ACT_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_ss(req_ss), .i_req_data(req_data),
    .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_ss(o_ss), .o_m_data(o_m_data), .o_m_dv(o_m_dv),
    .i_m_active(m_active), .i_m_data(m_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(~o_ss) > 1) bad_ss = bad_ss + 1;
      if (o_m_dv && (&o_ss)) bad_dv = bad_dv + 1;
      if (o_m_dv) dv_cnt = dv_cnt + 1;
    end
  end

  // master model: active rises two edges after dv, lasts 8 cycles, returns the selected slave's word
  always begin
    @(negedge clk);
    if (master_en && o_m_dv) begin
      tx_seen = o_m_data;
      for (int s = 0; s < NS; s++) if (!o_ss[s]) rx_sel = s;
      repeat (2) @(posedge clk);
      #1 m_active = 1'b1;
      repeat (8) @(posedge clk);
      #1 m_data = slave_word[rx_sel];
      m_active = 1'b0;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_ss !== 3'b111) begin errors++; $display("FAIL reset_ss got %b want 111", o_ss); end
    checks++; if ({o_m_dv, o_gnt, o_done, o_err, o_busy} !== 7'b0) begin errors++;
      $display("FAIL reset_ctrl got %b want 0", {o_m_dv, o_gnt, o_done, o_err, o_busy}); end
    checks++; if ({o_m_data, o_rdata} !== 16'h0) begin errors++;
      $display("FAIL reset_data got %h want 0000", {o_m_data, o_rdata}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr;
    logic [NR-1:0] exp_g, exp_d;
    int ng, nd;
    slave_word[0] = 8'h5A; slave_word[1] = 8'hC6; slave_word[2] = 8'h00;
    req_ss = {2'd1, 2'd0}; req_data = {8'h3C, 8'hA5}; req = 2'b11;
    ng = 0; nd = 0; exp_g = 2'b01; exp_d = 2'b01;
    for (int i = 0; i < 400 && nd < 4; i++) begin
      @(negedge clk);
      if (o_gnt != '0) begin
        checks++; if (o_gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d got %b want %b", ng, o_gnt, exp_g); end
        ng++; exp_g = {exp_g[0], exp_g[1]};
        if (ng == 4) req = '0;
      end
      if (o_done != '0) begin
        checks++; if (o_done !== exp_d) begin errors++; $display("FAIL rr_done%0d got %b want %b", nd, o_done, exp_d); end
        checks++; if (o_rdata !== (exp_d[0] ? 8'h5A : 8'hC6)) begin errors++;
          $display("FAIL rr_rdata%0d got %h want %h", nd, o_rdata, exp_d[0] ? 8'h5A : 8'hC6); end
        checks++; if (tx_seen !== (exp_d[0] ? 8'hA5 : 8'h3C)) begin errors++;
          $display("FAIL rr_tx%0d got %h want %h", nd, tx_seen, exp_d[0] ? 8'hA5 : 8'h3C); end
        nd++; exp_d = {exp_d[0], exp_d[1]};
      end
    end
    checks++; if (nd !== 4) begin errors++; $display("FAIL rr_count got %0d want 4", nd); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int t_ss, t_dv, t_fall, t_done, dv_w;
    logic was_act, got_gnt;
    slave_word[1] = 8'h69;
    req_ss[1:0] = 2'd1; req_data[7:0] = 8'hF0; req = 2'b01;
    t_ss = -1; t_dv = -1; t_fall = -1; t_done = -1; dv_w = 0; was_act = 1'b0; got_gnt = 1'b0;
    for (int i = 0; i < 200 && t_done < 0; i++) begin
      @(negedge clk);
      if (o_gnt != '0 && !got_gnt) begin
        got_gnt = 1'b1; t_ss = cyc; req = '0;
        checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", o_gnt); end
        checks++; if (o_ss !== 3'b101) begin errors++; $display("FAIL single_ss got %b want 101", o_ss); end
        checks++; if (o_m_data !== 8'hF0 || o_busy !== 1'b1) begin errors++;
          $display("FAIL single_mdata got %h/%b want f0/1", o_m_data, o_busy); end
      end
      if (o_m_dv) begin dv_w++; if (t_dv < 0) t_dv = cyc; end
      if (m_active) was_act = 1'b1;
      else if (was_act && t_fall < 0) t_fall = cyc;
      if (o_done != '0) begin
        t_done = cyc;
        checks++; if (o_done !== 2'b01 || o_err !== 1'b0) begin errors++;
          $display("FAIL single_done got %b/%b want 01/0", o_done, o_err); end
        checks++; if (o_rdata !== 8'h69) begin errors++; $display("FAIL single_rdata got %h want 69", o_rdata); end
        checks++; if (o_ss !== 3'b111) begin errors++; $display("FAIL single_ss_rel got %b want 111", o_ss); end
        checks++; if (tx_seen !== 8'hF0) begin errors++; $display("FAIL single_tx got %h want f0", tx_seen); end
      end
    end
    checks++; if (t_done < 0) begin errors++; $display("FAIL single_timeout got no done want done"); end
    checks++; if (t_dv - t_ss !== SETUP) begin errors++; $display("FAIL single_setup got %0d want %0d", t_dv - t_ss, SETUP); end
    checks++; if (dv_w !== 1) begin errors++; $display("FAIL single_dv_width got %0d want 1", dv_w); end
    // the fall is first seen the cycle before the edge that samples it
    checks++; if (t_done - t_fall !== HOLD + 1) begin errors++;
      $display("FAIL single_hold got %0d want %0d", t_done - t_fall, HOLD + 1); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_done !== 2'b00 || o_rdata !== 8'h69) begin errors++;
      $display("FAIL single_after got %b/%b/%h want 0/00/69", o_busy, o_done, o_rdata); end
    @(negedge clk);
  endtask

  task automatic test_bad_index;
    int dv0;
    logic seen;
    dv0 = dv_cnt; seen = 1'b0;
    req_ss[3:2] = 2'd3; req_data[15:8] = 8'h77; req = 2'b10;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_gnt != '0) begin
        seen = 1'b1; req = '0;
        checks++; if (o_gnt !== 2'b10 || o_done !== 2'b10 || o_err !== 1'b1) begin errors++;
          $display("FAIL bad_gnt_done got %b/%b/%b want 10/10/1", o_gnt, o_done, o_err); end
        checks++; if (o_ss !== 3'b111 || o_rdata !== 8'h69) begin errors++;
          $display("FAIL bad_ss_rdata got %b/%h want 111/69", o_ss, o_rdata); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL bad_timeout got no grant want grant"); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_done !== 2'b00 || o_err !== 1'b0) begin errors++;
      $display("FAIL bad_after got %b/%b/%b want 0/00/0", o_busy, o_done, o_err); end
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL bad_no_dv got %0d want %0d", dv_cnt, dv0); end
  endtask

  task automatic test_timeout;
    int t_dv, t_done;
    master_en = 1'b0;
    req_ss[1:0] = 2'd0; req_data[7:0] = 8'h42; req = 2'b01;
    t_dv = -1; t_done = -1;
    for (int i = 0; i < 100 && t_done < 0; i++) begin
      @(negedge clk);
      if (o_gnt != '0) req = '0;
      if (o_m_dv && t_dv < 0) t_dv = cyc;
      if (o_done != '0) begin
        t_done = cyc;
        checks++; if (o_done !== 2'b01 || o_err !== 1'b1) begin errors++;
          $display("FAIL tmo_done got %b/%b want 01/1", o_done, o_err); end
        checks++; if (o_rdata !== 8'h69 || o_ss !== 3'b111) begin errors++;
          $display("FAIL tmo_rdata_ss got %h/%b want 69/111", o_rdata, o_ss); end
      end
    end
    // dv cycle, then TMO waiting cycles, then HOLD cycles of select
    checks++; if (t_done < 0 || t_done - t_dv !== TMO + 1 + HOLD) begin errors++;
      $display("FAIL tmo_latency got %0d want %0d", t_done - t_dv, TMO + 1 + HOLD); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got %b want 0", o_busy); end
    master_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic act;
    int nd;
    slave_word[1] = 8'h81;
    req_ss[1:0] = 2'd1; req_data[7:0] = 8'hC3; req = 2'b01;
    act = 1'b0; nd = 0;
    for (int i = 0; i < 100 && !act; i++) begin
      @(negedge clk);
      if (o_gnt != '0) req = '0;
      act = m_active;
    end
    checks++; if (!act) begin errors++; $display("FAIL rstmid_active got 0 want 1"); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_ss !== 3'b111 || o_m_dv !== 1'b0 || o_busy !== 1'b0) begin errors++;
      $display("FAIL rstmid_outs got %b/%b/%b want 111/0/0", o_ss, o_m_dv, o_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (o_done != '0) nd++;
    end
    checks++; if (nd !== 0 || o_rdata !== 8'h00) begin errors++;
      $display("FAIL rstmid_no_done got %0d/%h want 0/00", nd, o_rdata); end
  endtask

  task automatic test_after_reset;
    logic seen;
    slave_word[0] = 8'hE7;
    req_ss[3:2] = 2'd0; req_data[15:8] = 8'h99; req = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (o_gnt != '0) begin
        req = '0;
        checks++; if (o_gnt !== 2'b10 || o_ss !== 3'b110) begin errors++;
          $display("FAIL post_gnt got %b/%b want 10/110", o_gnt, o_ss); end
      end
      if (o_done != '0) begin
        seen = 1'b1;
        checks++; if (o_done !== 2'b10 || o_err !== 1'b0 || o_rdata !== 8'hE7) begin errors++;
          $display("FAIL post_done got %b/%b/%h want 10/0/e7", o_done, o_err, o_rdata); end
        checks++; if (tx_seen !== 8'h99) begin errors++; $display("FAIL post_tx got %h want 99", tx_seen); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL post_timeout got no done want done"); end
    checks++; if (bad_ss !== 0 || bad_dv !== 0) begin errors++;
      $display("FAIL ss_dv_rules got %0d/%0d want 0/0", bad_ss, bad_dv); end
  endtask

  initial begin
    slave_word[0] = '0; slave_word[1] = '0; slave_word[2] = '0;
    test_reset();
    test_rr();
    test_single();
    test_bad_index();
    test_timeout();
    test_reset_mid();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
